// File: rtl/button_gesture.sv
// button_gesture: classifies debounced press/release pulses into short, double and
// long presses, with auto-repeat while a long press is held. All outputs registered.
module button_gesture #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned DBL_CYCLES    = 30_000_000,
    parameter int unsigned REPEAT_CYCLES = 20_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_state,
    input  logic i_ondn,
    input  logic i_onup,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWait2,
        StDrain,
        StLong
    } state_e;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DblLast    = CNT_W'(DBL_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic             ev_dn, ev_up;

    // The debounced level is informational only; gestures are driven by the pulses.
    logic unused_state;
    assign unused_state = i_state;

    // Simultaneous press and release pulses cancel; the cycle then acts as event-free.
    assign ev_dn = i_ondn & ~i_onup;
    assign ev_up = i_onup & ~i_ondn;

    // Saturating increment so the counter can never wrap.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, counter and pulse decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A stray release here is the tail of an aborted gesture.
                if (ev_dn) begin
                    state_d = StPress1;
                end
            end
            StPress1: begin
                if (ev_up) begin
                    state_d = StWait2;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    state_d = StLong;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWait2: begin
                if (ev_dn) begin
                    state_d  = StDrain;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else if (cnt_q == DblLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDrain: begin
                // Second press of a double: just wait for it to end.
                cnt_d = '0;
                if (ev_up) begin
                    state_d = StIdle;
                end
            end
            StLong: begin
                if (ev_up) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == RepeatLast) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Disable overrides every event and timeout.
        if (!i_en) begin
            state_d  = StIdle;
            cnt_d    = '0;
            short_d  = 1'b0;
            double_d = 1'b0;
            long_d   = 1'b0;
            repeat_d = 1'b0;
        end

        held_d = (state_d == StLong);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign o_short  = short_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_held   = held_q;

endmodule

// File: tb/tb_button_gesture.sv
// Testbench for button_gesture: directed gesture scenarios plus randomized traffic,
// each cycle compared against a timestamp-based gesture model.
module tb_button_gesture;

    localparam int LongC = 20;
    localparam int DblC  = 10;
    localparam int RepC  = 5;

    // Model phases: what the user is doing, tracked with timestamps not counters.
    localparam int MNone   = 0;
    localparam int MFirst  = 1;
    localparam int MGap    = 2;
    localparam int MSecond = 3;
    localparam int MHeld   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_en = 1'b0;
    logic i_state = 1'b0;
    logic i_ondn = 1'b0;
    logic i_onup = 1'b0;
    logic o_short, o_double, o_long, o_repeat, o_held;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    int m_mode = MNone;
    int m_t = 0;
    logic [4:0] exp_v = 5'b0;

    button_gesture #(
        .LONG_CYCLES  (LongC),
        .DBL_CYCLES   (DblC),
        .REPEAT_CYCLES(RepC),
        .CNT_W        (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (i_en),
        .i_state (i_state),
        .i_ondn  (i_ondn),
        .i_onup  (i_onup),
        .o_short (o_short),
        .o_double(o_double),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_held  (o_held)
    );

    always #5 clk = ~clk;

    // Expected outputs for the cycle after input cycle c; exp_v = {short,double,long,repeat,held}.
    task automatic model(input logic [2:0] s, input int c);
        logic en, dn, up, e_s, e_d, e_l, e_r;
        en = s[2];
        dn = s[1] && !s[0];
        up = s[0] && !s[1];
        e_s = 0; e_d = 0; e_l = 0; e_r = 0;
        if (!en) begin
            m_mode = MNone;
        end else begin
            case (m_mode)
                MNone: if (dn) begin m_mode = MFirst; m_t = c; end
                MFirst: begin
                    if (up) begin m_mode = MGap; m_t = c; end
                    else if (c - m_t == LongC) begin e_l = 1; m_mode = MHeld; m_t = c; end
                end
                MGap: begin
                    if (dn) begin e_d = 1; m_mode = MSecond; end
                    else if (c - m_t == DblC) begin e_s = 1; m_mode = MNone; end
                end
                MSecond: if (up) m_mode = MNone;
                MHeld: begin
                    if (up) m_mode = MNone;
                    else if ((c - m_t) % RepC == 0) e_r = 1;
                end
                default: m_mode = MNone;
            endcase
        end
        exp_v = {e_s, e_d, e_l, e_r, m_mode == MHeld};
    endtask

    // Drive one cycle of {en,dn,up}; afterwards outputs belong to observation cycle cyc.
    task automatic step(input logic [2:0] s);
        i_en = s[2];
        i_ondn = s[1];
        i_onup = s[0];
        if (s[1] && !s[0]) i_state = 1'b1;
        else if (s[0] && !s[1]) i_state = 1'b0;
        model(s, cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_n(inout logic [2:0] q[$], input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) q.push_back(s);
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        i_en = 1'b1;
        #12;
        obs = {o_short, o_double, o_long, o_repeat, o_held};
        n_checks++;
        if (obs !== 5'b0) $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_mode = MNone;
    endtask

    task automatic test_short();
        logic [2:0] q[$];
        logic [4:0] obs;
        int t, n_s, n_o, s_cyc;
        n_s = 0; n_o = 0; s_cyc = -1; t = 0;
        q.push_back(3'b110);
        push_n(q, 3'b100, 4);
        q.push_back(3'b101);
        push_n(q, 3'b100, 20);
        foreach (q[i]) begin
            if (i == 5) t = cyc;
            step(q[i]);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL short_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            if (obs[4]) begin n_s++; s_cyc = cyc; end
            n_o += $countones(obs[3:0]);
        end
        n_checks++;
        if (n_s != 1 || s_cyc != t + 11)
            $display("FAIL short_timing got count=%0d cyc=%0d exp count=1 cyc=%0d", n_s, s_cyc, t + 11);
        else n_pass++;
        n_checks++;
        if (n_o != 0) $display("FAIL short_others got=%0d exp=0", n_o);
        else n_pass++;
    endtask

    task automatic test_double();
        logic [2:0] q[$];
        logic [4:0] obs;
        int t, n_d, n_s, d_cyc;
        n_d = 0; n_s = 0; d_cyc = -1; t = 0;
        q.push_back(3'b110);
        push_n(q, 3'b100, 2);
        q.push_back(3'b101);
        push_n(q, 3'b100, 4);
        q.push_back(3'b110);
        push_n(q, 3'b100, 3);
        q.push_back(3'b101);
        push_n(q, 3'b100, 15);
        foreach (q[i]) begin
            if (i == 3) t = cyc;
            step(q[i]);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL double_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            if (obs[3]) begin n_d++; d_cyc = cyc; end
            if (obs[4]) n_s++;
        end
        n_checks++;
        if (n_d != 1 || d_cyc != t + 6 || n_s != 0)
            $display("FAIL double_timing got d=%0d cyc=%0d s=%0d exp d=1 cyc=%0d s=0",
                     n_d, d_cyc, n_s, t + 6);
        else n_pass++;
    endtask

    task automatic test_long();
        logic [2:0] q[$];
        logic [4:0] obs;
        int t, l_cyc, n_h, h_first, h_last;
        int r_cyc[$];
        l_cyc = -1; n_h = 0; h_first = -1; h_last = -1;
        t = cyc;
        q.push_back(3'b110);
        push_n(q, 3'b100, 31);
        q.push_back(3'b101);
        push_n(q, 3'b100, 5);
        foreach (q[i]) begin
            step(q[i]);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL long_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            if (obs[2]) l_cyc = cyc;
            if (obs[1]) r_cyc.push_back(cyc);
            if (obs[0]) begin
                n_h++;
                if (h_first < 0) h_first = cyc;
                h_last = cyc;
            end
        end
        n_checks++;
        if (l_cyc != t + 21) $display("FAIL long_timing got=%0d exp=%0d", l_cyc, t + 21);
        else n_pass++;
        n_checks++;
        if (r_cyc.size() != 2 || r_cyc[0] != t + 26 || r_cyc[1] != t + 31)
            $display("FAIL repeat_timing got n=%0d exp n=2 at %0d,%0d", r_cyc.size(), t + 26, t + 31);
        else n_pass++;
        n_checks++;
        if (n_h != 12 || h_first != t + 21 || h_last != t + 32)
            $display("FAIL held_window got n=%0d %0d..%0d exp n=12 %0d..%0d",
                     n_h, h_first, h_last, t + 21, t + 32);
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [2:0] q[$];
        logic [4:0] obs;
        int t, n_l, n_s, d_cyc;
        n_l = 0; n_s = 0; d_cyc = -1;
        t = cyc;
        q.push_back(3'b110);
        push_n(q, 3'b100, 19);
        q.push_back(3'b101);
        push_n(q, 3'b100, 9);
        q.push_back(3'b110);
        push_n(q, 3'b100, 2);
        q.push_back(3'b101);
        push_n(q, 3'b100, 15);
        foreach (q[i]) begin
            step(q[i]);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL boundary_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            if (obs[2]) n_l++;
            if (obs[4]) n_s++;
            if (obs[3]) d_cyc = cyc;
        end
        n_checks++;
        if (n_l != 0 || n_s != 0 || d_cyc != t + 31)
            $display("FAIL boundary_result got l=%0d s=%0d d_cyc=%0d exp l=0 s=0 d_cyc=%0d",
                     n_l, n_s, d_cyc, t + 31);
        else n_pass++;
    endtask

    task automatic test_reset_en();
        logic [4:0] obs;
        int n_p;
        n_p = 0;
        step(3'b110);
        for (int i = 0; i < 22; i++) step(3'b100);
        obs = {o_short, o_double, o_long, o_repeat, o_held};
        n_checks++;
        if (obs[0] !== 1'b1) $display("FAIL reach_long got held=%b exp=1", obs[0]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {o_short, o_double, o_long, o_repeat, o_held};
        n_checks++;
        if (obs !== 5'b0) $display("FAIL async_reset got=%b exp=%b", obs, 5'b0);
        else n_pass++;
        m_mode = MNone;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b101);
        for (int i = 0; i < 5; i++) step(3'b100);
        step(3'b110);
        for (int i = 0; i < 3; i++) step(3'b100);
        step(3'b000);
        step(3'b101);
        for (int i = 0; i < 25; i++) begin
            step(3'b100);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL en_abort_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            n_p += $countones(obs);
        end
        n_checks++;
        if (n_p != 0) $display("FAIL en_abort_quiet got=%0d exp=0", n_p);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [2:0] q[$];
        logic [4:0] obs;
        int t, n_p_idle, l_cyc;
        n_p_idle = 0; l_cyc = -1;
        q.push_back(3'b111);
        push_n(q, 3'b100, 25);
        foreach (q[i]) begin
            step(q[i]);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL both_idle_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            n_p_idle += $countones(obs);
        end
        n_checks++;
        if (n_p_idle != 0) $display("FAIL both_idle_quiet got=%0d exp=0", n_p_idle);
        else n_pass++;
        q.delete();
        t = cyc;
        q.push_back(3'b110);
        push_n(q, 3'b100, 2);
        q.push_back(3'b111);
        push_n(q, 3'b100, 20);
        q.push_back(3'b101);
        push_n(q, 3'b100, 3);
        foreach (q[i]) begin
            step(q[i]);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL both_press_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            if (obs[2]) l_cyc = cyc;
        end
        n_checks++;
        if (l_cyc != t + 21) $display("FAIL both_press_long got=%0d exp=%0d", l_cyc, t + 21);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0] obs;
        logic [2:0] s;
        logic phys, en, dn, up;
        int timer;
        phys = 0; timer = 3;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 79) != 0);
            dn = 0; up = 0;
            if (timer == 0) begin
                if (!phys) begin dn = 1; phys = 1; timer = $urandom_range(1, 40); end
                else begin up = 1; phys = 0; timer = $urandom_range(1, 16); end
            end else begin
                timer--;
            end
            if ($urandom_range(0, 199) == 0) begin dn = 1; up = 1; end
            s = {en, dn, up};
            step(s);
            obs = {o_short, o_double, o_long, o_repeat, o_held};
            n_checks++;
            if (obs !== exp_v) $display("FAIL random_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else n_pass++;
            n_checks++;
            if ($countones(obs[4:1]) > 1) $display("FAIL one_pulse cyc=%0d got=%b exp=<=1 pulse", cyc, obs);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long();
        test_boundary();
        test_reset_en();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
